eng_loader: RTL and testbench
=============================

ENG_LOADER -- requirements
Module: eng_loader

Interface
REQ-001 Parameters: NUM_ENGINE (default 2), number of BCP engines; CLAUSE_PER_ENGINE (default 4), CLQ nodes per engine; LIT_IDX_MAX (default 128), header entries per engine = 2*LIT_IDX_MAX+1; MAX_ITER (default 64), max initial unit clauses.
REQ-002 Ports: clk in 1, sole clock; rst_n in 1, synchronous active-high reset (asserted = 1, despite the name); start in 1, one-cycle load request; num_uc in $clog2(MAX_ITER+1), UC count, sampled on start.
REQ-003 Memory ports: clq_addr out, clause-node buffer address; clq_rd out 1; clq_data in node_t. hdr_addr out; hdr_rd out 1; hdr_data in dummy_entry_t. uc_addr out; uc_rd out 1; uc_data in lit_t. All three memories return data exactly 1 cycle after rd.
REQ-004 Engine side: node_in out node_t; node_in_valid out 1; change_eng out 1; dummy_ptr out dummy_entry_t; dummy_ptr_valid out 1; halt out 1; mem2uca out lit_t; mem2uca_valid out 1; mem2uca_done out 1; stall in 1; conflict in 1.
REQ-005 Status: busy out 1; done out 1, sticky until next start; conflict_seen out 1, sticky.

Function
REQ-006 FSM states IDLE, LOAD_CLQ, LOAD_HDR, RUN_UC, DONE; start is ignored outside IDLE and DONE.
REQ-007 IDLE/DONE + start -> LOAD_CLQ; done and conflict_seen clear; counters zero.
REQ-008 LOAD_CLQ: one clq_rd per cycle, addresses 0..NUM_ENGINE*CLAUSE_PER_ENGINE-1; node_in/node_in_valid registered 1 cycle after each read; the stream has no gaps.
REQ-009 change_eng = 1 with node index i exactly when i != 0 and i mod CLAUSE_PER_ENGINE == 0; otherwise 0.
REQ-010 After the last CLQ read issues, go to LOAD_HDR the next cycle; the final node_in_valid pulse overlaps the first header read cycle.
REQ-011 LOAD_HDR: hdr_addr 0..NUM_ENGINE*(2*LIT_IDX_MAX+1)-1 in engine-major order; dummy_ptr_valid registered 1 cycle after each read, contiguous.
REQ-012 After the last header beat is presented, enter RUN_UC; halt = 1 in every state except RUN_UC.
REQ-013 RUN_UC: edge detect on stall (stall & !stall_q); on each rising edge, while idx < num_uc, issue uc_rd at uc_addr = idx; the next cycle drive mem2uca = uc_data with mem2uca_valid = mem2uca_done = 1 for exactly one cycle; idx++.
REQ-014 No second UC is issued until a new stall rising edge; a stall held high issues only one UC.
REQ-015 mem2uca = 0 whenever mem2uca_valid = 0.
REQ-016 RUN_UC -> DONE when idx == num_uc and the last mem2uca pulse is complete; num_uc == 0 -> DONE directly from LOAD_HDR.
REQ-017 conflict = 1 in RUN_UC sets conflict_seen and goes to DONE the next cycle; a UC read already issued still presents its single pulse.
REQ-018 busy = 1 in LOAD_CLQ, LOAD_HDR, RUN_UC; done = 1 in DONE.

Reset
REQ-019 rst_n = 1 on a rising clk edge -> IDLE; all valid, rd, done, conflict_seen, busy and change_eng outputs 0; halt = 1; data outputs 0; counters 0.
REQ-020 Reset mid-operation aborts immediately; no partial valid pulse appears after the reset edge.

Configuration
REQ-021 With LOADER_PERF_CNT_EN defined: 32-bit outputs perf_load_cycles (cycles in LOAD_CLQ+LOAD_HDR) and perf_uc_cycles (cycles in RUN_UC), saturating, cleared on start and reset.
REQ-022 With LOADER_PERF_CNT_EN undefined, these ports and counters are absent; all other behaviour is identical.

Structure
REQ-023 node_t, dummy_entry_t, lit_t, NUM_ENGINE, LIT_IDX_MAX, MAX_ITER and the FSM state enum belong in the shared package.
REQ-024 One sub-module, eng_loader_seq: a generic 1-cycle-latency read sequencer (start, count, addr, rd, valid), instanced for both CLQ and header phases.

Verification
REQ-025 NUM_ENGINE=2, CLAUSE_PER_ENGINE=3, start -> 6 contiguous node_in_valid beats in address order; change_eng high only with node 3.
REQ-026 LIT_IDX_MAX=2 -> 10 contiguous dummy_ptr_valid beats, hdr_addr 0..9, beginning the cycle after the last node beat.
REQ-027 num_uc=3, uc memory {5,-7,9}, stall pulsed low->high 3 times -> 3 single-cycle mem2uca pulses 5, -7, 9, each 2 cycles after its edge; then done=1, halt=1.
REQ-028 stall held high 20 cycles in RUN_UC -> exactly one mem2uca pulse.
REQ-029 conflict=1 after UC 1 of 3 -> conflict_seen=1, DONE, no further UC issued.
REQ-030 rst_n=1 during LOAD_HDR -> next cycle all valids 0, halt=1, IDLE; a new start reloads from node 0.

Source files
------------

// File: rtl/eng_loader_pkg.sv
// eng_loader_pkg: shared types, defaults and FSM states for the BCP engine loader.
package eng_loader_pkg;

    localparam int NUM_ENGINE  = 2;
    localparam int LIT_IDX_MAX = 128;
    localparam int MAX_ITER    = 64;

    typedef logic [15:0] lit_t;
    typedef logic [15:0] dummy_entry_t;

    typedef struct packed {
        lit_t lit0;
        lit_t lit1;
    } node_t;

    typedef enum logic [2:0] {IDLE, LOAD_CLQ, LOAD_HDR, RUN_UC, DONE} state_t;

    function automatic logic eng_boundary(input int unsigned i, input int unsigned per);
        return i != 0 && i % per == 0;
    endfunction

endpackage

// File: rtl/eng_loader_seq.sv
// eng_loader_seq: issues count reads at addresses 0..count-1, one per cycle;
// valid marks the cycle the 1-cycle-latency memory returns each beat.
module eng_loader_seq #(
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [AW-1:0] count,
    output logic [AW-1:0] addr,
    output logic          rd,
    output logic          valid
);

    always_ff @(posedge clk) begin
        if (rst) begin
            addr  <= '0;
            rd    <= 1'b0;
            valid <= 1'b0;
        end else begin
            valid <= rd;
            if (start) begin
                rd   <= 1'b1;
                addr <= '0;
            end else if (rd && addr == count - 1'b1) begin
                rd   <= 1'b0;
                addr <= '0;
            end else if (rd) begin
                addr <= addr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/eng_loader.sv
// eng_loader: streams clause nodes and header entries into the BCP engines, then
// feeds initial unit clauses on stall edges. Optional LOADER_PERF_CNT_EN adds cycle counters.
module eng_loader import eng_loader_pkg::*; #(
    parameter int NUM_ENGINE        = eng_loader_pkg::NUM_ENGINE,
    parameter int CLAUSE_PER_ENGINE = 4,
    parameter int LIT_IDX_MAX       = eng_loader_pkg::LIT_IDX_MAX,
    parameter int MAX_ITER          = eng_loader_pkg::MAX_ITER,
    localparam int CLQ_N            = NUM_ENGINE * CLAUSE_PER_ENGINE,
    localparam int HDR_N            = NUM_ENGINE * (2 * LIT_IDX_MAX + 1),
    localparam int CLQ_AW           = $clog2(CLQ_N + 1),
    localparam int HDR_AW           = $clog2(HDR_N + 1),
    localparam int UC_W             = $clog2(MAX_ITER + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [UC_W-1:0]   num_uc,
    output logic [CLQ_AW-1:0] clq_addr,
    output logic              clq_rd,
    input  node_t             clq_data,
    output logic [HDR_AW-1:0] hdr_addr,
    output logic              hdr_rd,
    input  dummy_entry_t      hdr_data,
    output logic [UC_W-1:0]   uc_addr,
    output logic              uc_rd,
    input  lit_t              uc_data,
    output node_t             node_in,
    output logic              node_in_valid,
    output logic              change_eng,
    output dummy_entry_t      dummy_ptr,
    output logic              dummy_ptr_valid,
    output logic              halt,
    output lit_t              mem2uca,
    output logic              mem2uca_valid,
    output logic              mem2uca_done,
    input  logic              stall,
    input  logic              conflict,
    output logic              busy,
    output logic              done,
`ifdef LOADER_PERF_CNT_EN
    output logic [31:0]       perf_load_cycles,
    output logic [31:0]       perf_uc_cycles,
`endif
    output logic              conflict_seen
);

    localparam logic [CLQ_AW-1:0] CLQ_CNT = CLQ_AW'(CLQ_N);
    localparam logic [HDR_AW-1:0] HDR_CNT = HDR_AW'(HDR_N);

    state_t          state;
    logic [UC_W-1:0] num_q, idx;
    logic            stall_q, launch, clq_last, hdr_end, uc_issue, uc_fin;

    assign launch   = start && (state == IDLE || state == DONE);
    assign clq_last = clq_rd && clq_addr == CLQ_CNT - 1'b1;
    assign hdr_end  = state == LOAD_HDR && dummy_ptr_valid && !hdr_rd;
    assign uc_issue = state == RUN_UC && stall && !stall_q && idx < num_q && !conflict;
    assign uc_fin   = idx == num_q && !uc_rd;

    eng_loader_seq #(.AW(CLQ_AW)) u_clq (
        .clk(clk), .rst(rst_n), .start(launch), .count(CLQ_CNT),
        .addr(clq_addr), .rd(clq_rd), .valid(node_in_valid)
    );

    eng_loader_seq #(.AW(HDR_AW)) u_hdr (
        .clk(clk), .rst(rst_n), .start(clq_last), .count(HDR_CNT),
        .addr(hdr_addr), .rd(hdr_rd), .valid(dummy_ptr_valid)
    );

    // Memory data is already aligned with the registered valids; gate it so idle outputs read 0.
    assign node_in      = node_in_valid ? clq_data : '0;
    assign dummy_ptr    = dummy_ptr_valid ? hdr_data : '0;
    assign mem2uca      = mem2uca_valid ? uc_data : '0;
    assign mem2uca_done = mem2uca_valid;

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state         <= IDLE;
            num_q         <= '0;
            idx           <= '0;
            stall_q       <= 1'b0;
            uc_rd         <= 1'b0;
            uc_addr       <= '0;
            mem2uca_valid <= 1'b0;
            change_eng    <= 1'b0;
            halt          <= 1'b1;
            busy          <= 1'b0;
            done          <= 1'b0;
            conflict_seen <= 1'b0;
        end else begin
            stall_q       <= stall;
            uc_rd         <= uc_issue;
            mem2uca_valid <= uc_rd;
            change_eng    <= clq_rd && eng_boundary(32'(clq_addr), CLAUSE_PER_ENGINE);
            if (uc_issue) begin
                uc_addr <= idx;
                idx     <= idx + 1'b1;
            end
            case (state)
                IDLE, DONE: if (start) begin
                    state         <= LOAD_CLQ;
                    num_q         <= num_uc;
                    idx           <= '0;
                    busy          <= 1'b1;
                    done          <= 1'b0;
                    conflict_seen <= 1'b0;
                end
                LOAD_CLQ: if (clq_last) state <= LOAD_HDR;
                LOAD_HDR: if (hdr_end) begin
                    state <= num_q == '0 ? DONE : RUN_UC;
                    halt  <= num_q == '0;
                    busy  <= num_q != '0;
                    done  <= num_q == '0;
                end
                RUN_UC: if (conflict || uc_fin) begin
                    state         <= DONE;
                    halt          <= 1'b1;
                    busy          <= 1'b0;
                    done          <= 1'b1;
                    conflict_seen <= conflict;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef LOADER_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst_n || launch) begin
            perf_load_cycles <= '0;
            perf_uc_cycles   <= '0;
        end else begin
            if ((state == LOAD_CLQ || state == LOAD_HDR) && ~&perf_load_cycles)
                perf_load_cycles <= perf_load_cycles + 32'd1;
            if (state == RUN_UC && ~&perf_uc_cycles)
                perf_uc_cycles <= perf_uc_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_eng_loader.sv
// tb_eng_loader: directed bench for eng_loader with 2 engines, 3 clauses each, LIT_IDX_MAX 2.
module tb_eng_loader;
    import eng_loader_pkg::*;

    logic        clk, rst_n, start, stall, conflict;
    logic [6:0]  num_uc, uc_addr;
    logic [2:0]  clq_addr;
    logic [3:0]  hdr_addr;
    logic        clq_rd, hdr_rd, uc_rd;
    node_t       clq_data, node_in;
    dummy_entry_t hdr_data, dummy_ptr;
    lit_t        uc_data, mem2uca;
    logic        node_in_valid, change_eng, dummy_ptr_valid, halt;
    logic        mem2uca_valid, mem2uca_done, busy, done, conflict_seen;

    node_t        clq_mem [6];
    dummy_entry_t hdr_mem [10];
    lit_t         uc_mem  [4];

    int checks = 0;
    int errors = 0;

    eng_loader #(.NUM_ENGINE(2), .CLAUSE_PER_ENGINE(3), .LIT_IDX_MAX(2), .MAX_ITER(64)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .num_uc(num_uc),
        .clq_addr(clq_addr), .clq_rd(clq_rd), .clq_data(clq_data),
        .hdr_addr(hdr_addr), .hdr_rd(hdr_rd), .hdr_data(hdr_data),
        .uc_addr(uc_addr), .uc_rd(uc_rd), .uc_data(uc_data),
        .node_in(node_in), .node_in_valid(node_in_valid), .change_eng(change_eng),
        .dummy_ptr(dummy_ptr), .dummy_ptr_valid(dummy_ptr_valid), .halt(halt),
        .mem2uca(mem2uca), .mem2uca_valid(mem2uca_valid), .mem2uca_done(mem2uca_done),
        .stall(stall), .conflict(conflict), .busy(busy), .done(done),
        .conflict_seen(conflict_seen)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memories answer one cycle after each read strobe.
    always @(posedge clk) begin
        if (clq_rd) clq_data <= clq_mem[clq_addr];
        if (hdr_rd) hdr_data <= hdr_mem[hdr_addr];
        if (uc_rd)  uc_data  <= uc_mem[uc_addr[1:0]];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic launch(input logic [6:0] n);
        start  = 1'b1;
        num_uc = n;
        tick();
        start  = 1'b0;
    endtask

    // t counts negedges after the start edge; run says whether a UC phase follows.
    task automatic check_load(input bit run);
        for (int t = 1; t <= 18; t++) begin
            check("clq_rd", 32'(clq_rd), 32'(t <= 6));
            if (t <= 6) check("clq_addr", 32'(clq_addr), t - 1);
            check("node_vld", 32'(node_in_valid), 32'(t >= 2 && t <= 7));
            if (t >= 2 && t <= 7) check("node_in", 32'(node_in), 32'(clq_mem[t-2]));
            check("chg_eng", 32'(change_eng), 32'(t == 5));
            check("hdr_rd", 32'(hdr_rd), 32'(t >= 7 && t <= 16));
            if (t >= 7 && t <= 16) check("hdr_addr", 32'(hdr_addr), t - 7);
            check("dum_vld", 32'(dummy_ptr_valid), 32'(t >= 8 && t <= 17));
            if (t >= 8 && t <= 17) check("dum_ptr", 32'(dummy_ptr), 32'(hdr_mem[t-8]));
            check("halt", 32'(halt), 32'(run ? t < 18 : 1'b1));
            check("busy", 32'(busy), 32'(run ? 1'b1 : t < 18));
            check("done", 32'(done), 32'(!run && t >= 18));
            tick();
        end
    endtask

    task automatic uc_pulse(input int i, input lit_t v);
        stall = 1'b1;
        tick();
        check("uc_rd", 32'(uc_rd), 1);
        check("uc_addr", 32'(uc_addr), i);
        check("m_vld_pre", 32'(mem2uca_valid), 0);
        check("m_zero_pre", 32'(mem2uca), 0);
        tick();
        check("m_vld", 32'(mem2uca_valid), 1);
        check("m_done", 32'(mem2uca_done), 1);
        check("mem2uca", 32'(mem2uca), 32'(v));
        tick();
        check("m_vld_post", 32'(mem2uca_valid), 0);
        check("m_zero_post", 32'(mem2uca), 0);
        stall = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int pulses;
        for (int i = 0; i < 6; i++) clq_mem[i] = node_t'(32'hA000_0000 + 32'(i * 16'h0101));
        for (int i = 0; i < 10; i++) hdr_mem[i] = dummy_entry_t'(16'h0100 + 16'(i));
        uc_mem[0] = 16'd5;
        uc_mem[1] = -16'sd7;
        uc_mem[2] = 16'd9;
        uc_mem[3] = 16'd11;
        rst_n = 1'b1; start = 1'b0; stall = 1'b0; conflict = 1'b0; num_uc = '0;
        tick();
        tick();
        check("reset_ctl", 32'({busy, done, halt, conflict_seen, node_in_valid, dummy_ptr_valid,
              mem2uca_valid, mem2uca_done, change_eng, clq_rd, hdr_rd, uc_rd}), 32'b0010_0000_0000);
        check("reset_data", 32'(node_in) | 32'(dummy_ptr) | 32'(mem2uca), 0);
        rst_n = 1'b0;
        tick();

        // Full load followed by three unit clauses.
        launch(7'd3);
        check_load(1'b1);
        uc_pulse(0, 16'd5);
        check("halt_mid", 32'(halt), 0);
        uc_pulse(1, -16'sd7);
        check("busy_mid", 32'(busy), 1);
        uc_pulse(2, 16'd9);
        check("done_end", 32'(done), 1);
        check("halt_end", 32'(halt), 1);
        check("busy_end", 32'(busy), 0);

        // Restart from DONE; a held stall yields one UC, then a conflict ends the run.
        launch(7'd3);
        check("done_clr", 32'(done), 0);
        check_load(1'b1);
        stall = 1'b1;
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            pulses += int'(mem2uca_valid);
        end
        check("held_pulses", pulses, 1);
        stall = 1'b0;
        tick();
        conflict = 1'b1;
        tick();
        conflict = 1'b0;
        check("cflt_seen", 32'(conflict_seen), 1);
        check("cflt_done", 32'(done), 1);
        check("cflt_halt", 32'(halt), 1);
        pulses = 0;
        for (int k = 0; k < 3; k++) begin
            stall = 1'b1;
            tick();
            pulses += int'(uc_rd) + int'(mem2uca_valid);
            tick();
            pulses += int'(uc_rd) + int'(mem2uca_valid);
            stall = 1'b0;
            tick();
        end
        check("cflt_no_uc", pulses, 0);
        check("cflt_sticky", 32'(conflict_seen), 1);

        // Reset in the middle of the header phase, then reload with no unit clauses.
        launch(7'd2);
        for (int i = 0; i < 9; i++) tick();
        check("in_hdr", 32'(dummy_ptr_valid), 1);
        rst_n = 1'b1;
        tick();
        check("abort_ctl", 32'({busy, done, halt, conflict_seen, node_in_valid, dummy_ptr_valid,
              mem2uca_valid, change_eng, clq_rd, hdr_rd, uc_rd}), 32'b001_0000_0000);
        rst_n = 1'b0;
        tick();
        check("idle_quiet", 32'({node_in_valid, dummy_ptr_valid, clq_rd, hdr_rd, busy}), 0);
        launch(7'd0);
        check_load(1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
